vproc_bus_arbiter: RTL and testbench

//  Shares one downstream memory/peripheral bus between NUM_MASTERS VProc64 bus masters.

---
 rtl/vproc_arb_pkg.sv | 32 +++
 rtl/vproc_rr_picker.sv | 32 +++
 rtl/vproc_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_vproc_bus_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vproc_arb_pkg.sv
// Shared types and constants for the VProc64 bus arbiter.
package vproc_arb_pkg;

    localparam int unsigned MAX_MASTERS = 16;
    localparam int unsigned ADDR_W      = 64;
    localparam int unsigned DATA_W      = 64;
    localparam int unsigned BE_W        = 8;
    localparam int unsigned BURST_W     = 12;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // One master's view of the bus request, as forwarded downstream.
    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [BE_W-1:0]    be;
        logic               we;
        logic               rd;
        logic [DATA_W-1:0]  data;
        logic [BURST_W-1:0] burst;
        logic               first;
        logic               last;
    } bus_req_t;

    // Grant index width, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vproc_rr_picker.sv
// Round-robin requester selection: first requester above last_grant, wrapping.
module vproc_rr_picker
    import vproc_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last_grant,
    output logic [NUM_MASTERS-1:0] pick_c,
    output logic                   valid_c
);

    // Search masters above last_grant first, then wrap to the low end.
    always_comb begin
        pick_c  = '0;
        valid_c = 1'b0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (!valid_c && req[i] && (i > int'(last_grant))) begin
                pick_c[i] = 1'b1;
                valid_c   = 1'b1;
            end
        end
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (!valid_c && req[i] && (i <= int'(last_grant))) begin
                pick_c[i] = 1'b1;
                valid_c   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one downstream bus between VProc64 masters.
module vproc_bus_arbiter
    import vproc_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic                          Clk,
    input  logic                          nReset,
    input  logic [ADDR_W*NUM_MASTERS-1:0]  MAddr,
    input  logic [BE_W*NUM_MASTERS-1:0]    MBE,
    input  logic [NUM_MASTERS-1:0]         MWE,
    input  logic [NUM_MASTERS-1:0]         MRD,
    input  logic [DATA_W*NUM_MASTERS-1:0]  MDataOut,
    input  logic [BURST_W*NUM_MASTERS-1:0] MBurst,
    input  logic [NUM_MASTERS-1:0]         MBurstFirst,
    input  logic [NUM_MASTERS-1:0]         MBurstLast,
    output logic [DATA_W-1:0]              MDataIn,
    output logic [NUM_MASTERS-1:0]         MWRAck,
    output logic [NUM_MASTERS-1:0]         MRDAck,
    output logic [ADDR_W-1:0]              SAddr,
    output logic [BE_W-1:0]                SBE,
    output logic                           SWE,
    output logic                           SRD,
    output logic [DATA_W-1:0]              SDataOut,
    output logic [BURST_W-1:0]             SBurst,
    output logic                           SBurstFirst,
    output logic                           SBurstLast,
    input  logic [DATA_W-1:0]              SDataIn,
    input  logic                           SWRAck,
    input  logic                           SRDAck,
    output logic [NUM_MASTERS-1:0]         Grant,
    output logic                           Busy,
    output logic                           TimeoutErr
);

    localparam int unsigned IDX_W      = idx_width(NUM_MASTERS);
    localparam int unsigned WDOG_W     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit          WDOG_EN    = (TIMEOUT != 0);
    localparam int unsigned WDOG_LIMIT = WDOG_EN ? (TIMEOUT - 1) : 0;

    if (NUM_MASTERS < 1 || NUM_MASTERS > MAX_MASTERS) begin : g_bad_cfg
        $error("vproc_bus_arbiter: NUM_MASTERS out of range");
    end

    arb_state_e              state, state_n;
    logic [NUM_MASTERS-1:0]  grant, grant_n;
    logic [IDX_W-1:0]        last_grant, last_grant_n;
    logic [WDOG_W-1:0]       wdog, wdog_n;
    logic                    timeout_err, timeout_err_n;

    logic [NUM_MASTERS-1:0]  req;
    logic [NUM_MASTERS-1:0]  pick;
    logic                    pick_valid;
    bus_req_t                mreq [NUM_MASTERS];
    bus_req_t                sel;
    logic [IDX_W-1:0]        grant_idx;
    logic                    ack;
    logic                    release_ok;

    // Unpack the flat per-master port vectors into request structs.
    always_comb begin
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            mreq[i].addr  = MAddr[ADDR_W*i +: ADDR_W];
            mreq[i].be    = MBE[BE_W*i +: BE_W];
            mreq[i].we    = MWE[i];
            mreq[i].rd    = MRD[i];
            mreq[i].data  = MDataOut[DATA_W*i +: DATA_W];
            mreq[i].burst = MBurst[BURST_W*i +: BURST_W];
            mreq[i].first = MBurstFirst[i];
            mreq[i].last  = MBurstLast[i];
            req[i]        = MRD[i] | MWE[i];
        end
    end

    vproc_rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_picker (
        .req        (req),
        .last_grant (last_grant),
        .pick_c     (pick),
        .valid_c    (pick_valid)
    );

    // Select the granted master's request and encode its index.
    always_comb begin
        sel       = '0;
        grant_idx = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (grant[i]) begin
                sel       = mreq[i];
                grant_idx = IDX_W'(i);
            end
        end
    end

    assign ack        = SWRAck | SRDAck;
    assign release_ok = ack & ((sel.burst == '0) | sel.last);

    // Downstream bus and ack demux; everything quiet unless a grant is held.
    always_comb begin
        SAddr       = '0;
        SBE         = '0;
        SWE         = 1'b0;
        SRD         = 1'b0;
        SDataOut    = '0;
        SBurst      = '0;
        SBurstFirst = 1'b0;
        SBurstLast  = 1'b0;
        MWRAck      = '0;
        MRDAck      = '0;
        if (state == ARB_BUSY) begin
            SAddr       = sel.addr;
            SBE         = sel.be;
            SWE         = sel.we;
            SRD         = sel.rd;
            SDataOut    = sel.data;
            SBurst      = sel.burst;
            SBurstFirst = sel.first;
            SBurstLast  = sel.last;
            MWRAck      = grant & {NUM_MASTERS{SWRAck}};
            MRDAck      = grant & {NUM_MASTERS{SRDAck}};
        end
    end

    assign MDataIn    = SDataIn;
    assign Grant      = grant;
    assign Busy       = (state == ARB_BUSY);
    assign TimeoutErr = timeout_err;

    // Next-state: grant on request, hold through bursts, release on last ack or watchdog.
    always_comb begin
        state_n       = state;
        grant_n       = grant;
        last_grant_n  = last_grant;
        wdog_n        = wdog;
        timeout_err_n = timeout_err;
        unique case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_n = pick;
                    state_n = ARB_BUSY;
                    wdog_n  = '0;
                end
            end
            ARB_BUSY: begin
                if (ack) begin
                    wdog_n = '0;
                    if (release_ok) begin
                        state_n      = ARB_IDLE;
                        grant_n      = '0;
                        last_grant_n = grant_idx;
                    end
                end else if (WDOG_EN && (wdog == WDOG_W'(WDOG_LIMIT))) begin
                    state_n       = ARB_IDLE;
                    grant_n       = '0;
                    last_grant_n  = grant_idx;
                    timeout_err_n = 1'b1;
                end else if (wdog != {WDOG_W{1'b1}}) begin
                    wdog_n = wdog + WDOG_W'(1);
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    // State register; master 0 wins the first arbitration after reset.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state       <= ARB_IDLE;
            grant       <= '0;
            last_grant  <= IDX_W'(NUM_MASTERS - 1);
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            last_grant  <= last_grant_n;
            wdog        <= wdog_n;
            timeout_err <= timeout_err_n;
        end
    end

endmodule

// File: tb/tb_vproc_bus_arbiter.sv
// Scenario bench for vproc_bus_arbiter with four masters and a short watchdog.
module tb_vproc_bus_arbiter;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] grant;
        logic [63:0]  addr;
        logic [63:0]  data;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic [64*N-1:0] maddr;
    logic [8*N-1:0]  mbe;
    logic [N-1:0]    mwe;
    logic [N-1:0]    mrd;
    logic [64*N-1:0] mdout;
    logic [12*N-1:0] mburst;
    logic [N-1:0]    mfirst;
    logic [N-1:0]    mlast;
    logic [63:0]     mdin;
    logic [N-1:0]    mwrack;
    logic [N-1:0]    mrdack;
    logic [63:0]     saddr;
    logic [7:0]      sbe;
    logic            swe;
    logic            srd;
    logic [63:0]     sdout;
    logic [11:0]     sburst;
    logic            sfirst;
    logic            slast;
    logic [63:0]     sdin;
    logic            swrack;
    logic            srdack;
    logic [N-1:0]    grant;
    logic            busy;
    logic            terr;
    logic [151:0]    s_all;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    assign s_all = {saddr, sbe, swe, srd, sdout, sburst, sfirst, slast};

    vproc_bus_arbiter #(
        .NUM_MASTERS (N),
        .TIMEOUT     (8)
    ) dut (
        .Clk         (clk),
        .nReset      (rst_n),
        .MAddr       (maddr),
        .MBE         (mbe),
        .MWE         (mwe),
        .MRD         (mrd),
        .MDataOut    (mdout),
        .MBurst      (mburst),
        .MBurstFirst (mfirst),
        .MBurstLast  (mlast),
        .MDataIn     (mdin),
        .MWRAck      (mwrack),
        .MRDAck      (mrdack),
        .SAddr       (saddr),
        .SBE         (sbe),
        .SWE         (swe),
        .SRD         (srd),
        .SDataOut    (sdout),
        .SBurst      (sburst),
        .SBurstFirst (sfirst),
        .SBurstLast  (slast),
        .SDataIn     (sdin),
        .SWRAck      (swrack),
        .SRDAck      (srdack),
        .Grant       (grant),
        .Busy        (busy),
        .TimeoutErr  (terr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic [63:0] addr_of(input int i);
        return 64'h0000_0000_0000_1000 + 64'(i) * 64'h100;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_master(input int i, input logic [63:0] addr, input logic we,
                              input logic rd, input logic [63:0] data,
                              input logic [11:0] burst, input logic first, input logic last);
        maddr[64*i +: 64]  = addr;
        mbe[8*i +: 8]      = 8'hFF;
        mwe[i]             = we;
        mrd[i]             = rd;
        mdout[64*i +: 64]  = data;
        mburst[12*i +: 12] = burst;
        mfirst[i]          = first;
        mlast[i]           = last;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        maddr  = '0;
        mbe    = '0;
        mwe    = '0;
        mrd    = '0;
        mdout  = '0;
        mburst = '0;
        mfirst = '0;
        mlast  = '0;
        sdin   = '0;
        swrack = 1'b0;
        srdack = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_grant(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < budget) begin
            step();
            cyc++;
            if (grant !== '0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        exp_t e;
        do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_master(i, addr_of(i), 1'b0, 1'b1, 64'h55, 12'd0, 1'b0, 1'b0);
        swrack = 1'b1;
        srdack = 1'b1;
        step();
        step();
        checks++; if (s_all !== '0) begin errors++; $display("FAIL reset_s_bus: got %h expected 0", s_all); end
        checks++; if (mrdack !== '0) begin errors++; $display("FAIL reset_rdack: got %b expected 0000", mrdack); end
        checks++; if (mwrack !== '0) begin errors++; $display("FAIL reset_wrack: got %b expected 0000", mwrack); end
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (busy !== 1'b0 || terr !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b terr=%b expected 0 0", busy, terr); end
        swrack = 1'b0;
        srdack = 1'b0;
        exp_q.delete();
        e.grant = 4'b0001; e.addr = addr_of(0); e.data = '0;
        exp_q.push_back(e);
        rst_n = 1'b1;
        step();
        e = exp_q.pop_front();
        checks++; if (grant !== e.grant) begin errors++; $display("FAIL reset_first_grant: got %b expected %b", grant, e.grant); end
        checks++; if (busy !== 1'b1 || saddr !== e.addr) begin errors++; $display("FAIL reset_first_bus: got busy=%b addr=%h expected 1 %h", busy, saddr, e.addr); end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   cyc;
        bit   ok;
        do_reset();
        exp_q.delete();
        for (int i = 0; i < N; i++) set_master(i, addr_of(i), 1'b0, 1'b1, '0, 12'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            e.grant = 4'(1 << (k % N)); e.addr = addr_of(k % N); e.data = '0;
            exp_q.push_back(e);
        end
        for (int k = 0; k < 5; k++) begin
            wait_grant(8, cyc, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_wait: no grant within 8 cycles at round %0d", k); return; end
            e = exp_q.pop_front();
            checks++; if (grant !== e.grant) begin errors++; $display("FAIL rr_grant: round %0d got %b expected %b", k, grant, e.grant); end
            if (k > 0) begin
                checks++; if (cyc !== 1) begin errors++; $display("FAIL rr_gap: round %0d got %0d cycles expected 1", k, cyc); end
            end
            step();
            step();
            srdack = 1'b1;
            #1;
            checks++; if (mrdack !== e.grant || mwrack !== '0) begin errors++; $display("FAIL rr_ack: got rd=%b wr=%b expected rd=%b wr=0000", mrdack, mwrack, e.grant); end
            checks++; if (saddr !== e.addr) begin errors++; $display("FAIL rr_addr: got %h expected %h", saddr, e.addr); end
            @(posedge clk);
            #1;
            srdack = 1'b0;
            if (k == 4) mrd = '0;
            checks++; if (grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL rr_release: got grant=%b busy=%b expected 0000 0", grant, busy); end
        end
        step();
    endtask

    task automatic test_burst_lock();
        exp_t e;
        int   cyc;
        bit   ok;
        exp_q.delete();
        set_master(1, addr_of(1), 1'b1, 1'b0, 64'hB000_0000_0000_0000, 12'd4, 1'b1, 1'b0);
        set_master(0, addr_of(0), 1'b0, 1'b1, '0, 12'd0, 1'b0, 1'b0);
        e.grant = 4'b0010; e.addr = addr_of(1); e.data = '0; exp_q.push_back(e);
        e.grant = 4'b0001; e.addr = addr_of(0); e.data = '0; exp_q.push_back(e);
        wait_grant(8, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_wait: no grant within 8 cycles"); return; end
        e = exp_q.pop_front();
        checks++; if (grant !== e.grant) begin errors++; $display("FAIL burst_grant: got %b expected %b", grant, e.grant); end
        for (int b = 0; b < 4; b++) begin
            set_master(1, addr_of(1), 1'b1, 1'b0, 64'hB000_0000_0000_0000 | 64'(b), 12'd4, b == 0, b == 3);
            swrack = 1'b1;
            #1;
            checks++; if (mwrack !== 4'b0010 || mrdack !== '0) begin errors++; $display("FAIL burst_ack: beat %0d got wr=%b rd=%b expected 0010 0000", b, mwrack, mrdack); end
            checks++; if (sdout !== (64'hB000_0000_0000_0000 | 64'(b)) || slast !== (b == 3) || swe !== 1'b1) begin
                errors++; $display("FAIL burst_data: beat %0d got data=%h last=%b we=%b expected %h %b 1", b, sdout, slast, swe, 64'hB000_0000_0000_0000 | 64'(b), b == 3);
            end
            step();
            swrack = 1'b0;
            checks++; if (grant !== ((b < 3) ? 4'b0010 : 4'b0000)) begin errors++; $display("FAIL burst_hold: beat %0d got %b expected %b", b, grant, (b < 3) ? 4'b0010 : 4'b0000); end
            if (b < 3) step();
        end
        set_master(1, '0, 1'b0, 1'b0, '0, 12'd0, 1'b0, 1'b0);
        wait_grant(8, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_next_wait: no grant within 8 cycles"); return; end
        e = exp_q.pop_front();
        checks++; if (grant !== e.grant) begin errors++; $display("FAIL burst_next_grant: got %b expected %b", grant, e.grant); end
        srdack = 1'b1;
        step();
        srdack = 1'b0;
        mrd[0] = 1'b0;
        step();
    endtask

    task automatic test_watchdog();
        exp_t e;
        int   cyc;
        int   n;
        bit   ok;
        exp_q.delete();
        set_master(2, addr_of(2), 1'b0, 1'b1, '0, 12'd0, 1'b0, 1'b0);
        set_master(3, addr_of(3), 1'b0, 1'b1, '0, 12'd0, 1'b0, 1'b0);
        e.grant = 4'b0100; e.addr = addr_of(2); e.data = '0; exp_q.push_back(e);
        e.grant = 4'b1000; e.addr = addr_of(3); e.data = '0; exp_q.push_back(e);
        e.grant = 4'b0100; e.addr = addr_of(2); e.data = '0; exp_q.push_back(e);
        wait_grant(8, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wdog_wait: no grant within 8 cycles"); return; end
        e = exp_q.pop_front();
        checks++; if (grant !== e.grant) begin errors++; $display("FAIL wdog_grant: got %b expected %b", grant, e.grant); end
        n = 0;
        while (grant === 4'b0100 && n < 20) begin
            n++;
            step();
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL wdog_cycles: got %0d busy cycles expected 8", n); end
        checks++; if (terr !== 1'b1 || grant !== '0) begin errors++; $display("FAIL wdog_expire: got terr=%b grant=%b expected 1 0000", terr, grant); end
        wait_grant(8, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wdog_next_wait: no grant within 8 cycles"); return; end
        e = exp_q.pop_front();
        checks++; if (grant !== e.grant) begin errors++; $display("FAIL wdog_next_grant: got %b expected %b", grant, e.grant); end
        srdack = 1'b1;
        #1;
        checks++; if (mrdack !== 4'b1000) begin errors++; $display("FAIL wdog_next_ack: got %b expected 1000", mrdack); end
        step();
        srdack = 1'b0;
        mrd[3] = 1'b0;
        wait_grant(8, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL wdog_retry_wait: no grant within 8 cycles"); return; end
        e = exp_q.pop_front();
        checks++; if (grant !== e.grant) begin errors++; $display("FAIL wdog_retry_grant: got %b expected %b", grant, e.grant); end
        srdack = 1'b1;
        step();
        srdack = 1'b0;
        mrd[2] = 1'b0;
        step();
        step();
        checks++; if (terr !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL wdog_sticky: got terr=%b busy=%b expected 1 0", terr, busy); end
    endtask

    task automatic test_reset_mid_burst();
        exp_t e;
        int   cyc;
        bit   ok;
        exp_q.delete();
        set_master(1, addr_of(1), 1'b1, 1'b0, 64'hC1, 12'd4, 1'b1, 1'b0);
        e.grant = 4'b0010; e.addr = addr_of(1); e.data = '0; exp_q.push_back(e);
        wait_grant(8, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL arst_wait: no grant within 8 cycles"); return; end
        e = exp_q.pop_front();
        checks++; if (grant !== e.grant) begin errors++; $display("FAIL arst_grant: got %b expected %b", grant, e.grant); end
        swrack = 1'b1;
        step();
        swrack = 1'b0;
        set_master(1, addr_of(1), 1'b1, 1'b0, 64'hC2, 12'd4, 1'b0, 1'b0);
        set_master(0, addr_of(0), 1'b0, 1'b1, '0, 12'd0, 1'b0, 1'b0);
        swrack = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (s_all !== '0 || mwrack !== '0) begin errors++; $display("FAIL arst_outputs: got s=%h wr=%b expected 0 0000", s_all, mwrack); end
        checks++; if (grant !== '0 || busy !== 1'b0 || terr !== 1'b0) begin errors++; $display("FAIL arst_state: got grant=%b busy=%b terr=%b expected 0000 0 0", grant, busy, terr); end
        swrack = 1'b0;
        set_master(1, addr_of(1), 1'b1, 1'b0, 64'hC3, 12'd0, 1'b0, 1'b0);
        e.grant = 4'b0001; e.addr = addr_of(0); e.data = '0; exp_q.push_back(e);
        e.grant = 4'b0010; e.addr = addr_of(1); e.data = '0; exp_q.push_back(e);
        step();
        rst_n = 1'b1;
        wait_grant(8, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL arst_prio_wait: no grant within 8 cycles"); return; end
        e = exp_q.pop_front();
        checks++; if (grant !== e.grant || cyc !== 1) begin errors++; $display("FAIL arst_prio: got %b after %0d cycles expected %b after 1", grant, cyc, e.grant); end
        srdack = 1'b1;
        step();
        srdack = 1'b0;
        mrd[0] = 1'b0;
        wait_grant(8, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL arst_second_wait: no grant within 8 cycles"); return; end
        e = exp_q.pop_front();
        checks++; if (grant !== e.grant) begin errors++; $display("FAIL arst_second: got %b expected %b", grant, e.grant); end
        swrack = 1'b1;
        #1;
        checks++; if (mwrack !== 4'b0010) begin errors++; $display("FAIL arst_second_ack: got %b expected 0010", mwrack); end
        step();
        swrack = 1'b0;
        set_master(1, '0, 1'b0, 1'b0, '0, 12'd0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_data_path();
        exp_t e;
        int   cyc;
        bit   ok;
        exp_q.delete();
        srdack = 1'b1;
        swrack = 1'b1;
        #1;
        checks++; if (mrdack !== '0 || mwrack !== '0) begin errors++; $display("FAIL idle_ack: got rd=%b wr=%b expected 0000 0000", mrdack, mwrack); end
        srdack = 1'b0;
        swrack = 1'b0;
        set_master(3, 64'h1000_0000_0000_0040, 1'b0, 1'b1, '0, 12'd0, 1'b0, 1'b0);
        e.grant = 4'b1000; e.addr = 64'h1000_0000_0000_0040; e.data = 64'hDEADBEEF_CAFEF00D;
        exp_q.push_back(e);
        wait_grant(8, cyc, ok);
        checks++; if (!ok) begin errors++; $display("FAIL data_wait: no grant within 8 cycles"); return; end
        e = exp_q.pop_front();
        checks++; if (grant !== e.grant) begin errors++; $display("FAIL data_grant: got %b expected %b", grant, e.grant); end
        checks++; if (saddr !== e.addr || srd !== 1'b1 || swe !== 1'b0) begin errors++; $display("FAIL data_addr: got %h rd=%b we=%b expected %h 1 0", saddr, srd, swe, e.addr); end
        sdin   = 64'hDEADBEEF_CAFEF00D;
        srdack = 1'b1;
        #1;
        checks++; if (mrdack !== e.grant || mdin !== e.data) begin errors++; $display("FAIL data_read: got ack=%b data=%h expected %b %h", mrdack, mdin, e.grant, e.data); end
        step();
        srdack = 1'b0;
        mrd[3] = 1'b0;
        step();
        checks++; if (grant !== '0) begin errors++; $display("FAIL data_release: got %b expected 0000", grant); end
    endtask

    initial begin
        rst_n  = 1'b0;
        maddr  = '0;
        mbe    = '0;
        mwe    = '0;
        mrd    = '0;
        mdout  = '0;
        mburst = '0;
        mfirst = '0;
        mlast  = '0;
        sdin   = '0;
        swrack = 1'b0;
        srdack = 1'b0;
        test_reset();
        test_round_robin();
        test_burst_lock();
        test_watchdog();
        test_reset_mid_burst();
        test_data_path();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
